mem_wb_stage: RTL and testbench

- Consumer end of the execute stage. Registers execute-stage results into Memory (M), runs a req/ack handshake with data memory for loads and stores, and registers into Writeback (W).
- Produces the forwarding sources ALUResultM and ResultW, and the stall request StallM for the hazard unit.
- Sits between the execute stage and the register file in the pipelined ARM core.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/mem_wb_stage_if.sv | 25 ++
 rtl/dmem_handshake.sv | 77 +++++++
 rtl/mem_wb_stage.sv | 123 ++++++++++++
 tb/tb_mem_wb_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the memory/writeback slice of the pipelined core.
package pipeline_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned REG_AW_DEF  = 4;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the M stage (master) and data memory (slave).
interface mem_wb_stage_if
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              DMemReq;
  logic              DMemWe;
  logic [DATA_W-1:0] DMemAddr;
  logic [DATA_W-1:0] DMemWData;
  logic [DATA_W-1:0] DMemRData;
  logic              DMemAck;

  modport master (
    output DMemReq, DMemWe, DMemAddr, DMemWData,
    input  DMemRData, DMemAck
  );

  modport slave (
    input  DMemReq, DMemWe, DMemAddr, DMemWData,
    output DMemRData, DMemAck
  );

endinterface

// File: rtl/dmem_handshake.sv
// Request/ack sequencing for the M-stage memory op: wait FSM, timeout counter,
// done tracking, stall request and the sticky timeout error flag.
module dmem_handshake
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_mem_op,
  input  logic i_ack,
  output logic o_req,
  output logic o_stall,
  output logic o_mem_err
);

  dmem_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_mem_err;

  logic w_req;
  logic w_ack;
  logic w_timeout_hit;
  logic w_complete;
  logic w_stall;

  // An ack in the same cycle as the counter limit wins: the data is valid.
  assign w_req         = i_mem_op & ~r_done;
  assign w_ack         = i_ack & w_req;
  assign w_timeout_hit = w_req & ~w_ack & (r_state == ST_WAIT) & (r_cnt == CNT_W'(TIMEOUT));
  assign w_complete    = w_ack | w_timeout_hit;
  assign w_stall       = w_req & ~w_complete;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      // E/M reloads whenever the stall is released, which also retires the op.
      if (!w_stall)        r_done <= 1'b0;
      else if (w_complete) r_done <= 1'b1;

      if (w_timeout_hit) r_mem_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_req && !w_ack) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (w_complete || !w_req) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt != '1) begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_req     = w_req;
  assign o_stall   = w_stall;
  assign o_mem_err = r_mem_err;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory and writeback stages: E/M and M/W pipeline registers, data-memory
// handshake and the writeback result mux.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  mem_wb_stage_if.master    dmem,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [REG_AW-1:0] RdM,
  output logic              RegWriteM,
  output logic [REG_AW-1:0] RdW,
  output logic              RegWriteW,
  output logic              PCSrcW,
  output logic [DATA_W-1:0] ResultW,
  output logic              StallM,
  output logic              MemErr
);

  logic              r_reg_write_m;
  logic              r_mem_to_reg_m;
  logic              r_mem_write_m;
  logic              r_pc_src_m;
  logic [REG_AW-1:0] r_rd_m;
  logic [DATA_W-1:0] r_alu_result_m;
  logic [DATA_W-1:0] r_write_data_m;

  logic              r_reg_write_w;
  logic              r_mem_to_reg_w;
  logic              r_pc_src_w;
  logic [REG_AW-1:0] r_rd_w;
  logic [DATA_W-1:0] r_alu_result_w;
  logic [DATA_W-1:0] r_read_data_w;

  logic              w_req;
  logic              w_stall;
  logic              w_mem_err;
  logic [DATA_W-1:0] w_read_data;

  dmem_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_handshake (
    .clk       (clk),
    .reset     (reset),
    .i_mem_op  (r_mem_to_reg_m | r_mem_write_m),
    .i_ack     (dmem.DMemAck),
    .o_req     (w_req),
    .o_stall   (w_stall),
    .o_mem_err (w_mem_err)
  );

  // Captured load data: real data on ack, zero when the access timed out.
  assign w_read_data = (dmem.DMemAck && w_req) ? dmem.DMemRData : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write_m  <= 1'b0;
      r_mem_to_reg_m <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_pc_src_m     <= 1'b0;
      r_rd_m         <= '0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
    end else if (!w_stall) begin
      r_reg_write_m  <= RegWriteE;
      r_mem_to_reg_m <= MemtoRegE;
      r_mem_write_m  <= MemWriteE;
      r_pc_src_m     <= PCSrcE;
      r_rd_m         <= RdE;
      r_alu_result_m <= ALUResultE;
      r_write_data_m <= WriteDataE;
    end
  end

  // A stalled M stage feeds a bubble into W so nothing is written back twice.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write_w  <= 1'b0;
      r_mem_to_reg_w <= 1'b0;
      r_pc_src_w     <= 1'b0;
      r_rd_w         <= '0;
      r_alu_result_w <= '0;
      r_read_data_w  <= '0;
    end else if (!w_stall) begin
      r_reg_write_w  <= r_reg_write_m;
      r_mem_to_reg_w <= r_mem_to_reg_m;
      r_pc_src_w     <= r_pc_src_m;
      r_rd_w         <= r_rd_m;
      r_alu_result_w <= r_alu_result_m;
      r_read_data_w  <= w_read_data;
    end else begin
      r_reg_write_w  <= 1'b0;
      r_pc_src_w     <= 1'b0;
    end
  end

  assign dmem.DMemReq   = w_req;
  assign dmem.DMemWe    = r_mem_write_m & w_req;
  assign dmem.DMemAddr  = r_alu_result_m;
  assign dmem.DMemWData = r_write_data_m;

  assign ALUResultM = r_alu_result_m;
  assign RdM        = r_rd_m;
  assign RegWriteM  = r_reg_write_m;
  assign RdW        = r_rd_w;
  assign RegWriteW  = r_reg_write_w;
  assign PCSrcW     = r_pc_src_w;
  assign ResultW    = r_mem_to_reg_w ? r_read_data_w : r_alu_result_w;
  assign StallM     = w_stall;
  assign MemErr     = w_mem_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cycle table, timeout and reset corner cases,
// then a randomized instruction stream against a transaction-level model.
module tb_mem_wb_stage;

  localparam int TO = 15;
  localparam int N  = 80;
  localparam int NV = 13;

  logic        clk;
  logic        reset;
  logic        RegWriteE, MemtoRegE, MemWriteE, PCSrcE;
  logic [3:0]  RdE;
  logic [31:0] ALUResultE, WriteDataE;
  logic [31:0] ALUResultM, ResultW;
  logic [3:0]  RdM, RdW;
  logic        RegWriteM, RegWriteW, PCSrcW, StallM, MemErr;

  int total = 0;
  int bad   = 0;

  mem_wb_stage_if #(.DATA_W(32)) dif ();

  mem_wb_stage #(.DATA_W(32), .REG_AW(4), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteE  (RegWriteE),
    .MemtoRegE  (MemtoRegE),
    .MemWriteE  (MemWriteE),
    .PCSrcE     (PCSrcE),
    .RdE        (RdE),
    .ALUResultE (ALUResultE),
    .WriteDataE (WriteDataE),
    .dmem       (dif.master),
    .ALUResultM (ALUResultM),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .PCSrcW     (PCSrcW),
    .ResultW    (ResultW),
    .StallM     (StallM),
    .MemErr     (MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw, m2r, mw, pcs;
    logic [3:0]  rd;
    logic [31:0] alu, wd, rdata;
    int          lat;
  } instr_t;

  typedef struct {
    logic        rw, pcs;
    logic [3:0]  rd;
    logic [31:0] val;
  } wb_t;

  typedef struct {
    logic [3:0]  ctl;      // {rw, m2r, mw, pcs}
    logic [3:0]  rd;
    logic [31:0] alu, wd;
    logic        ack;
    logic [31:0] rdata;
    logic [3:0]  xf;       // {stall, req, we, rww}
    logic [31:0] x_alum, x_wdata;
    logic [3:0]  x_rdw;
    logic [31:0] x_resw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_e(input instr_t x);
    RegWriteE  = x.rw;
    MemtoRegE  = x.m2r;
    MemWriteE  = x.mw;
    PCSrcE     = x.pcs;
    RdE        = x.rd;
    ALUResultE = x.alu;
    WriteDataE = x.wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk_i(input logic [3:0] ctl, input logic [3:0] rd,
                                  input logic [31:0] alu, input logic [31:0] wd);
    instr_t x;
    x = '{default: 0};
    x.rw = ctl[3]; x.m2r = ctl[2]; x.mw = ctl[1]; x.pcs = ctl[0];
    x.rd = rd; x.alu = alu; x.wd = wd;
    return x;
  endfunction

  function automatic vec_t mk(input logic [3:0] ctl, input logic [3:0] rd, input logic [31:0] alu,
                              input logic [31:0] wd, input logic ack, input logic [31:0] rdata,
                              input logic [3:0] xf, input logic [31:0] x_alum,
                              input logic [31:0] x_wdata, input logic [3:0] x_rdw,
                              input logic [31:0] x_resw);
    vec_t v;
    v.ctl = ctl; v.rd = rd; v.alu = alu; v.wd = wd; v.ack = ack; v.rdata = rdata;
    v.xf = xf; v.x_alum = x_alum; v.x_wdata = x_wdata; v.x_rdw = x_rdw; v.x_resw = x_resw;
    return v;
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    int     k;
    int     r;
    x = '{default: 0};
    k = int'($urandom_range(0, 9));
    x.rd    = 4'($urandom_range(0, 15));
    x.alu   = $urandom;
    x.rdata = $urandom;
    if (k <= 3) begin
      x.rw  = 1'($urandom_range(0, 7) != 0);
      x.pcs = 1'($urandom_range(0, 7) == 0);
    end else if (k <= 6) begin
      x.rw  = 1'b1;
      x.m2r = 1'b1;
    end else if (k <= 8) begin
      x.mw  = 1'b1;
      x.wd  = $urandom;
    end else begin
      x.pcs = 1'($urandom_range(0, 1));
    end
    r = int'($urandom_range(0, 19));
    if (r < 14)      x.lat = r % 5;
    else if (r < 17) x.lat = TO - 1;
    else             x.lat = TO + 1 + (r - 17);
    return x;
  endfunction

  vec_t   vt[NV];
  vec_t   v;
  instr_t zi, e, m;
  wb_t    w;
  int     n, age, lim, e_idx, cyc;
  logic   exp_err, exp_stall, memop;

  initial begin
    zi = '{default: 0};
    reset = 1'b0;
    set_e(zi);
    dif.DMemAck   = 1'b0;
    dif.DMemRData = '0;

    // Reset values
    #3;
    chk1("rst_stall", StallM, 1'b0);
    chk1("rst_req", dif.DMemReq, 1'b0);
    chk1("rst_we", dif.DMemWe, 1'b0);
    chk("rst_addr", dif.DMemAddr, 32'h0);
    chk("rst_alum", ALUResultM, 32'h0);
    chk1("rst_rww", RegWriteW, 1'b0);
    chk1("rst_pcsw", PCSrcW, 1'b0);
    chk("rst_resw", ResultW, 32'h0);
    chk1("rst_memerr", MemErr, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // ctl={rw,m2r,mw,pcs}  xf={stall,req,we,rww}
    vt[0]  = mk(4'b1000, 4'd3, 32'h10,  32'h0,    1'b1, 32'hAAAA5555, 4'b0000, 32'h0,   32'h0,    4'd0, 32'h0);
    vt[1]  = mk(4'b1100, 4'd5, 32'h100, 32'h0,    1'b1, 32'h11111111, 4'b0000, 32'h10,  32'h0,    4'd0, 32'h0);
    vt[2]  = mk(4'b1100, 4'd6, 32'h104, 32'h0,    1'b1, 32'hDEADBEEF, 4'b0101, 32'h100, 32'h0,    4'd3, 32'h10);
    vt[3]  = mk(4'b0010, 4'd0, 32'h200, 32'h1234, 1'b0, 32'h00005555, 4'b1101, 32'h104, 32'h0,    4'd5, 32'hDEADBEEF);
    vt[4]  = mk(4'b0010, 4'd0, 32'h200, 32'h1234, 1'b0, 32'h00005555, 4'b1100, 32'h104, 32'h0,    4'd0, 32'h0);
    vt[5]  = mk(4'b0010, 4'd0, 32'h200, 32'h1234, 1'b0, 32'h00005555, 4'b1100, 32'h104, 32'h0,    4'd0, 32'h0);
    vt[6]  = mk(4'b0010, 4'd0, 32'h200, 32'h1234, 1'b1, 32'hCAFEF00D, 4'b0100, 32'h104, 32'h0,    4'd0, 32'h0);
    vt[7]  = mk(4'b1000, 4'd7, 32'h77,  32'h0,    1'b0, 32'h00009999, 4'b1111, 32'h200, 32'h1234, 4'd6, 32'hCAFEF00D);
    vt[8]  = mk(4'b1000, 4'd7, 32'h77,  32'h0,    1'b0, 32'h00009999, 4'b1110, 32'h200, 32'h1234, 4'd0, 32'h0);
    vt[9]  = mk(4'b1000, 4'd7, 32'h77,  32'h0,    1'b1, 32'h00000012, 4'b0110, 32'h200, 32'h1234, 4'd0, 32'h0);
    vt[10] = mk(4'b0000, 4'd0, 32'h0,   32'h0,    1'b0, 32'h0,        4'b0000, 32'h77,  32'h0,    4'd0, 32'h0);
    vt[11] = mk(4'b0000, 4'd0, 32'h0,   32'h0,    1'b1, 32'h0000FFFF, 4'b0001, 32'h0,   32'h0,    4'd7, 32'h77);
    vt[12] = mk(4'b0000, 4'd0, 32'h0,   32'h0,    1'b0, 32'h0,        4'b0000, 32'h0,   32'h0,    4'd0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      set_e(mk_i(v.ctl, v.rd, v.alu, v.wd));
      dif.DMemAck   = v.ack;
      dif.DMemRData = v.rdata;
      @(negedge clk);
      chk1($sformatf("v%0d_stall", i), StallM, v.xf[3]);
      chk1($sformatf("v%0d_req", i), dif.DMemReq, v.xf[2]);
      chk1($sformatf("v%0d_we", i), dif.DMemWe, v.xf[1]);
      chk1($sformatf("v%0d_rww", i), RegWriteW, v.xf[0]);
      chk($sformatf("v%0d_alum", i), ALUResultM, v.x_alum);
      chk($sformatf("v%0d_wdata", i), dif.DMemWData, v.x_wdata);
      if (v.xf[2]) chk($sformatf("v%0d_addr", i), dif.DMemAddr, v.x_alum);
      if (v.xf[0]) begin
        chk($sformatf("v%0d_rdw", i), 32'(RdW), 32'(v.x_rdw));
        chk($sformatf("v%0d_resw", i), ResultW, v.x_resw);
      end
      step();
    end

    // Load that is never acknowledged: forced completion after TO stall cycles
    dif.DMemAck = 1'b0;
    set_e(mk_i(4'b1100, 4'd9, 32'h300, 32'h0));
    chk1("to_memerr_before", MemErr, 1'b0);
    step();
    set_e(zi);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      dif.DMemRData = $urandom;
      @(negedge clk);
      if (!StallM) break;
      n++;
      step();
    end
    chk("to_stall_len", 32'(n), 32'(TO));
    chk1("to_req_held", dif.DMemReq, 1'b1);
    step();
    chk1("to_rww", RegWriteW, 1'b1);
    chk("to_rdw", 32'(RdW), 32'd9);
    chk("to_resw", ResultW, 32'h0);
    chk1("to_memerr", MemErr, 1'b1);
    step();
    step();
    chk1("to_memerr_sticky", MemErr, 1'b1);

    // Reset while waiting on memory
    set_e(mk_i(4'b1100, 4'd10, 32'h400, 32'h0));
    step();
    set_e(zi);
    step();
    step();
    chk1("rw_pre_stall", StallM, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk1("rw_req", dif.DMemReq, 1'b0);
    chk1("rw_stall", StallM, 1'b0);
    chk1("rw_we", dif.DMemWe, 1'b0);
    chk("rw_addr", dif.DMemAddr, 32'h0);
    chk("rw_alum", ALUResultM, 32'h0);
    chk1("rw_rww", RegWriteW, 1'b0);
    chk("rw_resw", ResultW, 32'h0);
    chk1("rw_memerr", MemErr, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("rw_post_rww%0d", k), RegWriteW, 1'b0);
      chk1($sformatf("rw_post_req%0d", k), dif.DMemReq, 1'b0);
      step();
    end
    set_e(mk_i(4'b1100, 4'd11, 32'h500, 32'h0));
    step();
    set_e(zi);
    dif.DMemAck   = 1'b1;
    dif.DMemRData = 32'h600D;
    @(negedge clk);
    chk1("rw_zw_stall", StallM, 1'b0);
    chk1("rw_zw_req", dif.DMemReq, 1'b1);
    step();
    dif.DMemAck = 1'b0;
    chk1("rw_zw_rww", RegWriteW, 1'b1);
    chk("rw_zw_rdw", 32'(RdW), 32'd11);
    chk("rw_zw_resw", ResultW, 32'h600D);

    // Randomized stream against the transaction model
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
    step();
    m = zi;
    w = '{default: 0};
    age = 0;
    e_idx = 0;
    cyc = 0;
    exp_err = 1'b0;
    while (e_idx < N + 3) begin
      if (cyc >= 4000) begin
        total++;
        bad++;
        $display("FAIL rnd_budget: got %0d instructions expected %0d", e_idx, N + 3);
        break;
      end
      e = (e_idx < N) ? rand_instr() : zi;
      set_e(e);
      memop = m.m2r | m.mw;
      lim = (m.lat < TO) ? m.lat : TO;
      exp_stall = memop && (age < lim);
      if (memop) begin
        dif.DMemAck   = (age == m.lat);
        dif.DMemRData = (age == m.lat) ? m.rdata : $urandom;
      end else begin
        dif.DMemAck   = 1'($urandom_range(0, 1));
        dif.DMemRData = $urandom;
      end
      @(negedge clk);
      chk1("rnd_stall", StallM, exp_stall);
      chk1("rnd_req", dif.DMemReq, memop);
      chk1("rnd_we", dif.DMemWe, memop & m.mw);
      chk("rnd_alum", ALUResultM, m.alu);
      if (memop) chk("rnd_addr", dif.DMemAddr, m.alu);
      if (memop && m.mw) chk("rnd_wdata", dif.DMemWData, m.wd);
      chk1("rnd_rww", RegWriteW, w.rw);
      chk1("rnd_pcsw", PCSrcW, w.pcs);
      if (w.rw) begin
        chk("rnd_rdw", 32'(RdW), 32'(w.rd));
        chk("rnd_resw", ResultW, w.val);
      end
      chk1("rnd_memerr", MemErr, exp_err);
      if (!exp_stall) begin
        if (memop && m.lat > TO) exp_err = 1'b1;
        w.rw  = m.rw;
        w.pcs = m.pcs;
        w.rd  = m.rd;
        w.val = m.m2r ? ((m.lat > TO) ? 32'h0 : m.rdata) : m.alu;
        m     = e;
        age   = 0;
        e_idx++;
      end else begin
        w.rw  = 1'b0;
        w.pcs = 1'b0;
        age++;
      end
      step();
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
